// File: rtl/onehot_rr_arbiter.sv
// -----------------------------------------------------------------------------
// onehot_rr_arbiter
//   Eight-requester round-robin arbiter with a registered one-hot grant.
//   A grant is held until the consumer acknowledges it or until MAX_HOLD
//   cycles pass without an acknowledge, whichever comes first. After an
//   acknowledge the next grant can follow on the same edge. After a hold-limit
//   release there is one idle cycle, during which timeout is high.
//
//   Optional feature macro: ARB_IDX_OUT_EN. When it is defined, the block adds
//   the registered binary grant index port gnt_idx.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   req        in   8  request vector; any number of bits may be set
//   gnt        out  8  registered grant, one-hot or zero
//   gnt_valid  out  1  high while gnt holds a live grant
//   gnt_ack    in   1  consumer acknowledge; ignored while gnt_valid is low
//   timeout    out  1  one-cycle pulse when the hold limit releases a grant
//   gnt_idx    out  3  binary index of gnt; 0 when idle (ARB_IDX_OUT_EN only)
// -----------------------------------------------------------------------------
module onehot_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    input  logic       gnt_ack,
    output logic       timeout
`ifdef ARB_IDX_OUT_EN
    ,
    output logic [2:0] gnt_idx
`endif
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_cnt;
    logic [7:0] r_gnt;
    logic       r_gnt_valid;
    logic       r_timeout;
`ifdef ARB_IDX_OUT_EN
    logic [2:0] r_gnt_idx;
`endif

    logic [2:0] w_cur_idx;
    logic [2:0] w_next_ptr;
    logic [2:0] w_arb_ptr;
    logic [2:0] w_sel;
    logic       w_any;
    logic [7:0] w_sel_onehot;

    // Pick the first set bit of r at or above p, wrapping from 7 to 0. The
    // vector is rotated so that bit p lands at position 0, and the lowest set
    // bit of the rotated value is taken. The offset is then added back modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  off;
        dbl = {r, r} >> p;
        rot = dbl[7:0];
        off = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (rot[7 - i]) off = 3'(7 - i);
        end
        return p + off;
    endfunction

    always_comb begin
        w_cur_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r_gnt[i]) w_cur_idx = 3'(i);
        end
    end

    // While in GRANT, a release moves the pointer past the current winner.
    // Arbitration on that same edge therefore has to use the advanced pointer
    // and not the registered one.
    assign w_next_ptr   = w_cur_idx + 3'd1;
    assign w_arb_ptr    = (r_state == GRANT) ? w_next_ptr : r_ptr;
    assign w_sel        = rr_pick(req, w_arb_ptr);
    assign w_any        = |req;
    assign w_sel_onehot = 8'b1 << w_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef ARB_IDX_OUT_EN
            r_gnt_idx   <= '0;
`endif
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt       <= w_sel_onehot;
                        r_gnt_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= GRANT;
`ifdef ARB_IDX_OUT_EN
                        r_gnt_idx   <= w_sel;
`endif
                    end
                end
                GRANT: begin
                    // An acknowledge takes priority over a hold-limit
                    // release that happens on the same cycle.
                    if (gnt_ack) begin
                        r_ptr <= w_next_ptr;
                        r_cnt <= '0;
                        if (w_any) begin
                            r_gnt       <= w_sel_onehot;
`ifdef ARB_IDX_OUT_EN
                            r_gnt_idx   <= w_sel;
`endif
                        end else begin
                            r_gnt       <= '0;
                            r_gnt_valid <= 1'b0;
                            r_state     <= IDLE;
`ifdef ARB_IDX_OUT_EN
                            r_gnt_idx   <= '0;
`endif
                        end
                    end else if (r_cnt == HOLD_LAST) begin
                        r_ptr       <= w_next_ptr;
                        r_cnt       <= '0;
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_state     <= IDLE;
`ifdef ARB_IDX_OUT_EN
                        r_gnt_idx   <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;
`ifdef ARB_IDX_OUT_EN
    assign gnt_idx   = r_gnt_idx;
`endif

endmodule
